// File: rtl/cva6_icache_data_ctrl.sv
// Icache data-array port controller: refill writes, lookups and flush onto one SRAM port.
// Optional access counters enabled by defining CVA6_ICACHE_DATA_PERF_EN.
module cva6_icache_data_ctrl #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned WAY_COUNT = 1,
    localparam int unsigned AddrWidth = NumWords > 1 ? $clog2(NumWords) : 1,
    localparam int unsigned WayIdxW   = WAY_COUNT > 1 ? $clog2(WAY_COUNT) : 1,
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rd_valid_i,
    output logic                 rd_ready_o,
    input  logic [AddrWidth-1:0] rd_addr_i,
    input  logic [WayIdxW-1:0]   rd_way_i,
    output logic                 rd_rvalid_o,
    input  logic                 rd_rready_i,
    output logic [DataWidth-1:0] rd_rdata_o,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [AddrWidth-1:0] wr_addr_i,
    input  logic [WayIdxW-1:0]   wr_way_i,
    input  logic [DataWidth-1:0] wr_data_i,
    input  logic [BeWidth-1:0]   wr_be_i,
    input  logic                 flush_i,
    output logic                 flush_busy_o,
    output logic [WAY_COUNT-1:0] sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic [DataWidth-1:0] sram_rdata_i [WAY_COUNT]
`ifdef CVA6_ICACHE_DATA_PERF_EN
    ,
    output logic [31:0]          rd_cnt_o,
    output logic [31:0]          wr_cnt_o
`endif
);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_e;

    state_e               state_q;
    logic                 pend_q;
    logic                 rvalid_q;
    logic                 flush_pend_q;
    logic [WayIdxW-1:0]   way_q;
    logic [AddrWidth-1:0] cnt_q;
    logic [DataWidth-1:0] rdata_q;

    logic                 is_idle;
    logic                 in_flush;
    logic                 wr_hs;
    logic                 rd_hs;
    logic                 flush_go;
    logic                 cnt_last;
    logic [WAY_COUNT-1:0] wr_oh;
    logic [WAY_COUNT-1:0] rd_oh;
    logic [DataWidth-1:0] sel_data;

    // Handshakes are gated by rst_ni so nothing is accepted during reset.
    assign is_idle  = rst_ni && (state_q == IDLE);
    assign in_flush = rst_ni && (state_q == FLUSH);

    assign wr_ready_o = is_idle & ~flush_i & ~flush_pend_q;
    assign rd_ready_o = wr_ready_o & ~wr_valid_i & ~pend_q
                      & (~rvalid_q | rd_rready_i);

    assign wr_hs    = wr_valid_i & wr_ready_o;
    assign rd_hs    = rd_valid_i & rd_ready_o;
    assign flush_go = is_idle & (flush_i | flush_pend_q) & ~pend_q;
    assign cnt_last = (cnt_q == AddrWidth'(NumWords - 1));

    assign flush_busy_o = (state_q == FLUSH) | flush_pend_q;
    assign rd_rvalid_o  = rvalid_q;
    assign rd_rdata_o   = rdata_q;

    // Out-of-range way indices match no bit and select zero data.
    always_comb begin
        wr_oh    = '0;
        rd_oh    = '0;
        sel_data = '0;
        for (int w = 0; w < WAY_COUNT; w++) begin
            wr_oh[w] = (wr_way_i == WayIdxW'(w));
            rd_oh[w] = (rd_way_i == WayIdxW'(w));
            if (way_q == WayIdxW'(w)) begin
                sel_data = sram_rdata_i[w];
            end
        end
    end

    always_comb begin
        sram_req_o   = '0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        if (in_flush) begin
            sram_req_o  = '1;
            sram_we_o   = 1'b1;
            sram_addr_o = cnt_q;
            sram_be_o   = '1;
        end else if (wr_hs) begin
            sram_req_o   = wr_oh;
            sram_we_o    = 1'b1;
            sram_addr_o  = wr_addr_i;
            sram_wdata_o = wr_data_i;
            sram_be_o    = wr_be_i;
        end else if (rd_hs) begin
            sram_req_o  = rd_oh;
            sram_addr_o = rd_addr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            pend_q       <= 1'b0;
            rvalid_q     <= 1'b0;
            flush_pend_q <= 1'b0;
            way_q        <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (flush_go) begin
                        state_q      <= FLUSH;
                        flush_pend_q <= 1'b0;
                    end else if (flush_i && pend_q) begin
                        flush_pend_q <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (cnt_last) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase

            pend_q <= rd_hs;
            if (rd_hs) begin
                way_q <= rd_way_i;
            end

            // A capture wins over a drain so back-to-back responses have no bubble.
            if (pend_q) begin
                rvalid_q <= 1'b1;
                rdata_q  <= sel_data;
            end else if (rvalid_q && rd_rready_i) begin
                rvalid_q <= 1'b0;
            end
        end
    end

`ifdef CVA6_ICACHE_DATA_PERF_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_hs && (rd_cnt_q != 32'hFFFF_FFFF)) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (wr_hs && (wr_cnt_q != 32'hFFFF_FFFF)) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end

    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_cva6_icache_data_ctrl.sv
// Scoreboard bench for cva6_icache_data_ctrl with a 4-way, 16-line behavioural SRAM.
module tb_cva6_icache_data_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        rd_valid_i;
    logic        rd_ready_o;
    logic [3:0]  rd_addr_i;
    logic [1:0]  rd_way_i;
    logic        rd_rvalid_o;
    logic        rd_rready_i;
    logic [31:0] rd_rdata_o;
    logic        wr_valid_i;
    logic        wr_ready_o;
    logic [3:0]  wr_addr_i;
    logic [1:0]  wr_way_i;
    logic [31:0] wr_data_i;
    logic [3:0]  wr_be_i;
    logic        flush_i;
    logic        flush_busy_o;
    logic [3:0]  sram_req_o;
    logic        sram_we_o;
    logic [3:0]  sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [3:0]  sram_be_o;
    logic [31:0] rq [4];
    logic [31:0] mem [4][16];

    int total = 0;
    int bad   = 0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    cva6_icache_data_ctrl #(
        .NumWords (16),
        .DataWidth(32),
        .ByteWidth(8),
        .WAY_COUNT(4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .rd_valid_i  (rd_valid_i),
        .rd_ready_o  (rd_ready_o),
        .rd_addr_i   (rd_addr_i),
        .rd_way_i    (rd_way_i),
        .rd_rvalid_o (rd_rvalid_o),
        .rd_rready_i (rd_rready_i),
        .rd_rdata_o  (rd_rdata_o),
        .wr_valid_i  (wr_valid_i),
        .wr_ready_o  (wr_ready_o),
        .wr_addr_i   (wr_addr_i),
        .wr_way_i    (wr_way_i),
        .wr_data_i   (wr_data_i),
        .wr_be_i     (wr_be_i),
        .flush_i     (flush_i),
        .flush_busy_o(flush_busy_o),
        .sram_req_o  (sram_req_o),
        .sram_we_o   (sram_we_o),
        .sram_addr_o (sram_addr_o),
        .sram_wdata_o(sram_wdata_o),
        .sram_be_o   (sram_be_o),
        .sram_rdata_i(rq)
    );

    // Data-array macro: byte-masked writes, 1-cycle read latency, preset pattern on reset.
    always @(posedge clk) begin
        if (!rst_ni) begin
            for (int w = 0; w < 4; w++) begin
                rq[w] <= '0;
                for (int a = 0; a < 16; a++) mem[w][a] <= 32'hDEAD_BEEF;
            end
        end else begin
            for (int w = 0; w < 4; w++) begin
                if (sram_req_o[w]) begin
                    if (sram_we_o) begin
                        for (int b = 0; b < 4; b++)
                            if (sram_be_o[b])
                                mem[w][sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
                    end else begin
                        rq[w] <= mem[w][sram_addr_o];
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_ni && rd_rvalid_o && rd_rready_i) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got %h want none", rd_rdata_o);
            end else begin
                chk("resp_data", rd_rdata_o, sb.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [1:0] w,
                      input logic [31:0] d, input logic [3:0] be);
        wr_valid_i = 1'b1;
        wr_addr_i  = a;
        wr_way_i   = w;
        wr_data_i  = d;
        wr_be_i    = be;
        @(negedge clk);
        chk("wr_ready", 32'(wr_ready_o), 32'd1);
        chk("wr_req", 32'(sram_req_o), 32'd1 << w);
        chk("wr_we", 32'(sram_we_o), 32'd1);
        chk("wr_addr", 32'(sram_addr_o), 32'(a));
        chk("wr_wdata", sram_wdata_o, d);
        chk("wr_be", 32'(sram_be_o), 32'(be));
        cyc();
        wr_valid_i = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [1:0] w, input logic [31:0] exp);
        int n = 0;
        rd_valid_i = 1'b1;
        rd_addr_i  = a;
        rd_way_i   = w;
        @(negedge clk);
        while (!rd_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rd_ready_o) begin
            chk("rd_timeout", 32'(rd_ready_o), 32'd1);
        end else begin
            chk("rd_req", 32'(sram_req_o), 32'd1 << w);
            chk("rd_we", 32'(sram_we_o), 32'd0);
            chk("rd_addr", 32'(sram_addr_o), 32'(a));
            sb.push_back(exp);
        end
        cyc();
        rd_valid_i = 1'b0;
    endtask

    task automatic wait_flush_done();
        int n = 0;
        @(negedge clk);
        while (flush_busy_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("flush_done", 32'(flush_busy_o), 32'd0);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_ni      = 1'b0;
        rd_valid_i  = 1'b1;
        wr_valid_i  = 1'b1;
        rd_addr_i   = '0;
        rd_way_i    = '0;
        rd_rready_i = 1'b1;
        wr_addr_i   = '0;
        wr_way_i    = '0;
        wr_data_i   = '0;
        wr_be_i     = '0;
        flush_i     = 1'b0;

        // Reset: handshakes refused, SRAM quiet, response cleared.
        cyc();
        @(negedge clk);
        chk("rst_rd_ready", 32'(rd_ready_o), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready_o), 32'd0);
        chk("rst_req", 32'(sram_req_o), 32'd0);
        rd_valid_i = 1'b0;
        wr_valid_i = 1'b0;
        cyc();
        rst_ni = 1'b1;
        @(negedge clk);
        chk("rst_we", 32'(sram_we_o), 32'd0);
        chk("rst_addr", 32'(sram_addr_o), 32'd0);
        chk("rst_wdata", sram_wdata_o, 32'd0);
        chk("rst_be", 32'(sram_be_o), 32'd0);
        chk("rst_rvalid", 32'(rd_rvalid_o), 32'd0);
        chk("rst_rdata", rd_rdata_o, 32'd0);
        chk("rst_busy", 32'(flush_busy_o), 32'd0);
        cyc();

        // Write then read back with two-cycle latency.
        wr(4'd5, 2'd0, 32'hA5A5_A5A5, 4'hF);
        rd(4'd5, 2'd0, 32'hA5A5_A5A5);
        @(negedge clk);
        chk("lat_1", 32'(rd_rvalid_o), 32'd0);
        cyc();
        @(negedge clk);
        chk("lat_2", 32'(rd_rvalid_o), 32'd1);
        cyc();

        // Distinct data per way, read way 2; partial byte-enable merge.
        for (int w = 0; w < 4; w++) wr(4'd9, 2'(w), 32'h9000_0000 + 32'(w), 4'hF);
        rd(4'd9, 2'd2, 32'h9000_0002);
        wr(4'd3, 2'd1, 32'h3333_3333, 4'hF);
        wr(4'd3, 2'd1, 32'hFFFF_FFFF, 4'b0001);
        rd(4'd3, 2'd1, 32'h3333_33FF);
        repeat (4) cyc();

        // Read and write together: write wins, read goes next cycle.
        wr_valid_i = 1'b1;
        wr_addr_i  = 4'd4;
        wr_way_i   = 2'd1;
        wr_data_i  = 32'h4444_4444;
        wr_be_i    = 4'hF;
        rd_valid_i = 1'b1;
        rd_addr_i  = 4'd9;
        rd_way_i   = 2'd3;
        @(negedge clk);
        chk("both_wr_ready", 32'(wr_ready_o), 32'd1);
        chk("both_rd_ready", 32'(rd_ready_o), 32'd0);
        chk("both_req", 32'(sram_req_o), 32'b0010);
        chk("both_we", 32'(sram_we_o), 32'd1);
        cyc();
        wr_valid_i = 1'b0;
        @(negedge clk);
        chk("both_rd_next", 32'(rd_ready_o), 32'd1);
        chk("both_rd_req", 32'(sram_req_o), 32'b1000);
        chk("both_rd_we", 32'(sram_we_o), 32'd0);
        sb.push_back(32'h9000_0003);
        cyc();
        rd_valid_i = 1'b0;
        rd(4'd4, 2'd1, 32'h4444_4444);
        repeat (4) cyc();

        // Backpressure: response held, no new read issued.
        rd_rready_i = 1'b0;
        rd(4'd5, 2'd0, 32'hA5A5_A5A5);
        n = 0;
        @(negedge clk);
        while (!rd_rvalid_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rvalid", 32'(rd_rvalid_o), 32'd1);
        rd_valid_i = 1'b1;
        rd_addr_i  = 4'd9;
        rd_way_i   = 2'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rdata", rd_rdata_o, 32'hA5A5_A5A5);
            chk("bp_rd_ready", 32'(rd_ready_o), 32'd0);
            chk("bp_req", 32'(sram_req_o), 32'd0);
        end
        cyc();
        rd_rready_i = 1'b1;
        @(negedge clk);
        chk("bp_release", 32'(rd_ready_o), 32'd1);
        sb.push_back(32'h9000_0000);
        cyc();
        rd_valid_i = 1'b0;
        repeat (4) cyc();

        // Full flush walks every line of every way with zero data.
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("fl_busy", 32'(flush_busy_o), 32'd1);
            chk("fl_req", 32'(sram_req_o), 32'hF);
            chk("fl_we", 32'(sram_we_o), 32'd1);
            chk("fl_addr", 32'(sram_addr_o), 32'(i));
            chk("fl_wdata", sram_wdata_o, 32'd0);
            chk("fl_be", 32'(sram_be_o), 32'hF);
            if (i == 3) chk("fl_rd_ready", 32'(rd_ready_o), 32'd0);
            cyc();
        end
        @(negedge clk);
        chk("fl_end_busy", 32'(flush_busy_o), 32'd0);
        chk("fl_end_req", 32'(sram_req_o), 32'd0);
        cyc();
        rd(4'd5, 2'd0, 32'd0);
        rd(4'd9, 2'd2, 32'd0);
        rd(4'd15, 2'd3, 32'd0);
        repeat (4) cyc();

        // Flush requested while a read is outstanding is deferred one cycle.
        wr(4'd7, 2'd1, 32'h7777_7777, 4'hF);
        rd(4'd7, 2'd1, 32'h7777_7777);
        flush_i = 1'b1;
        @(negedge clk);
        chk("fp_wr_ready", 32'(wr_ready_o), 32'd0);
        chk("fp_req", 32'(sram_req_o), 32'd0);
        cyc();
        flush_i = 1'b0;
        @(negedge clk);
        chk("fp_busy", 32'(flush_busy_o), 32'd1);
        chk("fp_req2", 32'(sram_req_o), 32'd0);
        cyc();
        @(negedge clk);
        chk("fp_start_addr", 32'(sram_addr_o), 32'd0);
        chk("fp_start_req", 32'(sram_req_o), 32'hF);
        wait_flush_done();
        repeat (2) cyc();

        // Reset in flush cycle 7 aborts; next flush restarts at 0.
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("fr_addr", 32'(sram_addr_o), 32'(i));
            if (i < 7) cyc();
        end
        rst_ni = 1'b0;
        cyc();
        rst_ni = 1'b1;
        @(negedge clk);
        chk("fr_busy", 32'(flush_busy_o), 32'd0);
        chk("fr_req", 32'(sram_req_o), 32'd0);
        chk("fr_we", 32'(sram_we_o), 32'd0);
        cyc();
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        @(negedge clk);
        chk("fr_restart_addr", 32'(sram_addr_o), 32'd0);
        chk("fr_restart_busy", 32'(flush_busy_o), 32'd1);
        wait_flush_done();

        repeat (4) cyc();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cva6_icache_data_ctrl.md
Name: cva6_icache_data_ctrl

Overview:
- Initiator-side controller for the per-way icache data SRAM array (one shared address/write bus, per-way request vector, 1-cycle read latency).
- Arbitrates a refill write port, a lookup read port and a full-array flush onto the single SRAM port.
- Captures the selected way's read data into a response register with a valid/ready handshake.
- Sits between the icache FSM/refill logic and the data-array macro wrapper.

Parameters:
- NumWords, 1024, lines per way.
- DataWidth, 128, line/beat width in bits.
- ByteWidth, 8, bits per byte-enable lane.
- WAY_COUNT, 1, number of ways (≥1).
- AddrWidth, derived: NumWords>1 ? $clog2(NumWords) : 1. Do not override.
- WayIdxW, derived: WAY_COUNT>1 ? $clog2(WAY_COUNT) : 1. Do not override.
- BeWidth, derived: ceil(DataWidth/ByteWidth). Do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- rd_valid_i  in  1  lookup request valid.
- rd_ready_o  out  1  lookup request accepted.
- rd_addr_i  in  AddrWidth  lookup line index.
- rd_way_i  in  WayIdxW  way whose data is returned.
- rd_rvalid_o  out  1  response valid.
- rd_rready_i  in  1  response consumed.
- rd_rdata_o  out  DataWidth  response data.
- wr_valid_i  in  1  refill write valid.
- wr_ready_o  out  1  refill write accepted.
- wr_addr_i  in  AddrWidth  refill line index.
- wr_way_i  in  WayIdxW  refill target way.
- wr_data_i  in  DataWidth  refill data.
- wr_be_i  in  BeWidth  refill byte enables.
- flush_i  in  1  request zeroing of all ways.
- flush_busy_o  out  1  flush in progress.
- sram_req_o  out  WAY_COUNT  per-way SRAM request.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  AddrWidth  SRAM address.
- sram_wdata_o  out  DataWidth  SRAM write data.
- sram_be_o  out  BeWidth  SRAM byte enable.
- sram_rdata_i  in  DataWidth x WAY_COUNT (unpacked array)  SRAM read data, valid 1 cycle after req.

Behaviour:
- Reset (synchronous, rst_ni=0 at a clk_i edge):
  - State = IDLE; pend_q=0, rvalid_q=0, flush counter=0.
  - Outputs after reset: sram_req_o=0, sram_we_o=0, sram_addr_o=0, sram_wdata_o=0, sram_be_o=0.
  - rd_rvalid_o=0, rd_rdata_o=0, flush_busy_o=0.
  - rd_ready_o and wr_ready_o are 0 while rst_ni=0.
- Reset mid-flush or mid-read aborts the operation; no response is produced.
- FSM states:
  - IDLE: accepts operations.
  - FLUSH: walking the array.
  - IDLE→FLUSH when flush_i=1 and pend_q=0.
  - FLUSH→IDLE after the cycle that writes address NumWords-1.
  - flush_i is ignored while in FLUSH.
  - flush_i seen while pend_q=1 is held internally (flush_pend_q) and taken the next cycle.
- One SRAM access per cycle at most. Priority in IDLE: flush > write > read.
- Write:
  - wr_ready_o = IDLE & ~flush_i & ~flush_pend_q.
  - On wr_valid_i & wr_ready_o, in the same cycle (combinational): sram_req_o = onehot(wr_way_i), sram_we_o=1, and addr/wdata/be taken from the wr_* inputs.
  - Writes are accepted even while a read response is pending.
- Read:
  - rd_ready_o = IDLE & ~flush_i & ~flush_pend_q & ~wr_valid_i & ~pend_q & (~rvalid_q | rd_rready_i).
  - On handshake: sram_req_o = onehot(rd_way_i), sram_we_o=0, sram_addr_o = rd_addr_i. Latch the way index and set pend_q.
  - Next cycle: sram_rdata_i[way_q] is registered into rd_rdata_o; rvalid_q=1; pend_q=0.
  - Latency is 2 cycles from request handshake to rd_rvalid_o; maximum throughput is one read per 2 cycles.
  - rd_rdata_o and rd_rvalid_o hold stable until rd_rvalid_o & rd_rready_i.
  - A simultaneous drain and new capture replaces the response without a bubble.
- Flush:
  - Each FLUSH cycle drives sram_req_o = all ones, sram_we_o=1, sram_be_o = all ones, sram_wdata_o=0, sram_addr_o = counter.
  - The counter increments by 1 and wraps to 0 on exit.
  - Takes exactly NumWords cycles.
  - flush_busy_o=1 in FLUSH and while flush_pend_q=1.
  - An existing response register is preserved through the flush.
- Idle cycles: sram_req_o=0 and sram_we_o=0; other SRAM outputs are don't-care but driven deterministically (0).
- rd_way_i/wr_way_i ≥ WAY_COUNT: no SRAM request is issued. A read still completes, with rd_rdata_o=0.

Optional Feature:
- Macro: CVA6_ICACHE_DATA_PERF_EN.
- Defined:
  - Adds ports rd_cnt_o (out, 32) and wr_cnt_o (out, 32).
  - rd_cnt_o increments per read handshake; wr_cnt_o increments per write handshake. Flush writes are not counted.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports and counters are absent. All other behaviour is identical.

Test Plan:
- Write addr 5, way 0, data 0xA5…A5, be all ones; then read addr 5, way 0 → sram_req_o=1 with we=1 in the write cycle; rd_rvalid_o=1 two cycles after the read handshake with rd_rdata_o=0xA5…A5.
- WAY_COUNT=4: write distinct data to addr 9 in ways 0..3, then read way 2 → sram_req_o=4'b0100 on the read; rd_rdata_o = way-2 data.
- rd_valid_i and wr_valid_i both asserted in the same cycle → write issued, rd_ready_o=0; read issued next cycle.
- Hold rd_rready_i=0 for 5 cycles after a response → rd_rdata_o stable, rd_ready_o=0, no new SRAM read issued.
- flush_i with NumWords=16 → flush_busy_o high 16 cycles, addresses 0..15 written with zero; a subsequent read of any way returns 0.
- Assert rst_ni=0 at flush cycle 7 → next cycle is IDLE, flush_busy_o=0, sram_req_o=0; the counter restarts from 0 on the next flush.
